// File: rtl/mc_loop_fifo.sv
// Multi-channel input FIFOs feeding one iterative processing engine.
// Each channel buffers words independently; a round-robin arbiter hands one
// word at a time to the engine, which either rotates it or accumulates it
// NUM_LOOPS times before presenting the result with a valid/ready handshake.
module mc_loop_fifo #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned FIFO_WIDTH = 8,
   parameter int unsigned NUM_LOOPS  = 3,
   parameter int unsigned ADD_MODE   = 0
) (
   input  logic                                          clk,
   input  logic                                          rstn,
   input  logic [NUM_CH-1:0]                             push,
   input  logic [NUM_CH*FIFO_WIDTH-1:0]                  push_data,
   output logic [NUM_CH-1:0]                             full,
   output logic [NUM_CH-1:0]                             empty,
   output logic [NUM_CH-1:0]                             drop_err,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [FIFO_WIDTH-1:0]                         out_data,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch
);

   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned IT_W  = (NUM_LOOPS > 1) ? $clog2(NUM_LOOPS) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_LOOP, ST_OUT} state_t;

   logic [FIFO_WIDTH-1:0] mem_q [NUM_CH][FIFO_DEPTH];
   logic [PTR_W-1:0]      wptr_q [NUM_CH];
   logic [PTR_W-1:0]      wptr_d [NUM_CH];
   logic [PTR_W-1:0]      rptr_q [NUM_CH];
   logic [PTR_W-1:0]      rptr_d [NUM_CH];
   logic [CNT_W-1:0]      cnt_q  [NUM_CH];
   logic [CNT_W-1:0]      cnt_d  [NUM_CH];
   logic [NUM_CH-1:0]     full_q, full_d;
   logic [NUM_CH-1:0]     empty_q, empty_d;
   logic [NUM_CH-1:0]     drop_q, drop_d;
   logic [NUM_CH-1:0]     accept;
   logic [NUM_CH-1:0]     pop_vec;

   state_t                state_q, state_d;
   logic [FIFO_WIDTH-1:0] acc_q, acc_d;
   logic [FIFO_WIDTH-1:0] word_q, word_d;
   logic [CH_W-1:0]       ch_q, ch_d;
   logic [IT_W-1:0]       iter_q, iter_d;
   logic [CH_W-1:0]       last_q, last_d;

   logic                  found;
   logic [CH_W-1:0]       win;
   logic [FIFO_WIDTH-1:0] head;
   logic                  pop_en;

   // Round-robin pick: first non-empty channel after the last one served.
   always_comb begin
      int unsigned idx;
      idx   = 0;
      found = 1'b0;
      win   = '0;
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         idx = 32'(last_q) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!found && !empty_q[idx[CH_W-1:0]]) begin
            found = 1'b1;
            win   = idx[CH_W-1:0];
         end
      end
      head = mem_q[win][rptr_q[win]];
   end

   // Engine next-state: pop in IDLE, iterate in LOOP, hold result in OUT.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      word_d  = word_q;
      ch_d    = ch_q;
      iter_d  = iter_q;
      last_d  = last_q;
      pop_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               pop_en  = 1'b1;
               acc_d   = head;
               word_d  = head;
               ch_d    = win;
               last_d  = win;
               iter_d  = '0;
               state_d = ST_LOOP;
            end
         end
         ST_LOOP: begin
            if (ADD_MODE != 0) acc_d = acc_q + word_q;
            else               acc_d = {acc_q[FIFO_WIDTH-2:0], acc_q[FIFO_WIDTH-1]};
            if (iter_q == IT_W'(NUM_LOOPS - 1)) state_d = ST_OUT;
            else                                iter_d  = iter_q + 1'b1;
         end
         ST_OUT: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Per-channel pointer/count bookkeeping; a full channel still accepts
   // when the engine pops it in the same cycle.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      cnt_d   = cnt_q;
      accept  = '0;
      pop_vec = '0;
      full_d  = full_q;
      empty_d = empty_q;
      drop_d  = drop_q;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         pop_vec[c] = pop_en && (win == CH_W'(c));
         accept[c]  = push[c] && (!full_q[c] || pop_vec[c]);
         wptr_d[c]  = wptr_q[c] + PTR_W'(accept[c]);
         rptr_d[c]  = rptr_q[c] + PTR_W'(pop_vec[c]);
         cnt_d[c]   = cnt_q[c] + CNT_W'(accept[c]) - CNT_W'(pop_vec[c]);
         full_d[c]  = (cnt_d[c] == CNT_W'(FIFO_DEPTH));
         empty_d[c] = (cnt_d[c] == '0);
         drop_d[c]  = drop_q[c] | (push[c] & ~accept[c]);
      end
   end

   // FIFO storage: written only on accepted pushes outside reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (accept[c]) mem_q[c][wptr_q[c]] <= push_data[c*FIFO_WIDTH +: FIFO_WIDTH];
         end
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rstn) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            wptr_q[c] <= '0;
            rptr_q[c] <= '0;
            cnt_q[c]  <= '0;
         end
         full_q  <= '0;
         empty_q <= '1;
         drop_q  <= '0;
         state_q <= ST_IDLE;
         acc_q   <= '0;
         word_q  <= '0;
         ch_q    <= '0;
         iter_q  <= '0;
         last_q  <= CH_W'(NUM_CH - 1);
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         drop_q  <= drop_d;
         state_q <= state_d;
         acc_q   <= acc_d;
         word_q  <= word_d;
         ch_q    <= ch_d;
         iter_q  <= iter_d;
         last_q  <= last_d;
      end
   end

   assign full      = full_q;
   assign empty     = empty_q;
   assign drop_err  = drop_q;
   assign out_valid = (state_q == ST_OUT);
   assign out_data  = acc_q;
   assign out_ch    = ch_q;

endmodule

// File: tb/tb_mc_loop_fifo.sv
// Scoreboard bench for mc_loop_fifo: per-channel expected queues filled at
// push time, drained by an independent output monitor.
module tb_mc_loop_fifo;

   localparam int NC = 4;
   localparam int D  = 8;
   localparam int W  = 8;
   localparam int NL = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rstn;
   logic [NC-1:0]   push;
   logic [NC*W-1:0] push_data;
   logic [NC-1:0]   full, empty, drop_err;
   logic            out_valid, out_ready;
   logic [W-1:0]    out_data;
   logic [1:0]      out_ch;

   logic [NC-1:0]   a_push;
   logic [NC*W-1:0] a_pdata;
   logic [NC-1:0]   a_full, a_empty, a_drop;
   logic            a_valid, a_ready;
   logic [W-1:0]    a_data;
   logic [1:0]      a_ch;

   mc_loop_fifo #(.NUM_CH(NC), .FIFO_DEPTH(D), .FIFO_WIDTH(W), .NUM_LOOPS(NL), .ADD_MODE(0)) dut (
      .clk(clk), .rstn(rstn), .push(push), .push_data(push_data),
      .full(full), .empty(empty), .drop_err(drop_err),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch));

   mc_loop_fifo #(.NUM_CH(NC), .FIFO_DEPTH(D), .FIFO_WIDTH(W), .NUM_LOOPS(NL), .ADD_MODE(1)) u_add (
      .clk(clk), .rstn(rstn), .push(a_push), .push_data(a_pdata),
      .full(a_full), .empty(a_empty), .drop_err(a_drop),
      .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data), .out_ch(a_ch));

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int n_out = 0;
   logic [W-1:0] exp_q [NC][$];
   int outst [NC];
   int obs_ch [$];
   int obs_cyc [$];
   int obs_dat [$];

   always @(posedge clk) cyc <= cyc + 1;

   // Rotate-left by NUM_LOOPS in one step.
   function automatic logic [W-1:0] ref_rot(input logic [W-1:0] w);
      logic [2*W-1:0] t;
      t = {w, w} << (NL % W);
      return t[2*W-1:W];
   endfunction

   function automatic logic [W-1:0] ref_add(input logic [W-1:0] w);
      int t;
      t = int'(w) * (NL + 1);
      return t[W-1:0];
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_sb;
      for (int c = 0; c < NC; c++) begin
         exp_q[c].delete();
         outst[c] = 0;
      end
   endtask

   task automatic do_reset;
      rstn = 1'b1;
      clear_sb();
      tick();
      tick();
      rstn = 1'b0;
   endtask

   task automatic stage_push(input int c, input logic [W-1:0] w);
      push[c] = 1'b1;
      push_data[c*W +: W] = w;
      exp_q[c].push_back(ref_rot(w));
      outst[c]++;
   endtask

   task automatic clear_obs;
      obs_ch.delete();
      obs_cyc.delete();
      obs_dat.delete();
   endtask

   task automatic drain(input int maxc, input string nm);
      int k;
      int left;
      k = 0;
      left = 1;
      while (left != 0 && k < maxc) begin
         @(negedge clk);
         left = 0;
         for (int c = 0; c < NC; c++) left += outst[c];
         k++;
      end
      if (left != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: drain timeout, %0d words outstanding, 0 required", nm, left);
      end
   endtask

   // Output monitor: every handshake must match the head of its channel queue.
   always @(negedge clk) begin : mon
      int c;
      if (!rstn && out_valid && out_ready) begin
         c = int'(out_ch);
         if (c >= NC || exp_q[c].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected: ch=%0d data=0x%0h, no output expected", c, out_data);
         end else begin
            chk("sb_data", int'(out_data), int'(exp_q[c].pop_front()));
            outst[c]--;
         end
         obs_ch.push_back(c);
         obs_cyc.push_back(cyc);
         obs_dat.push_back(int'(out_data));
         n_out++;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int c0;
      int n0;
      int k;
      int ch;
      logic [W-1:0] w;

      rstn = 1'b1;
      push = '0;
      push_data = '0;
      out_ready = 1'b0;
      a_push = '0;
      a_pdata = '0;
      a_ready = 1'b1;
      clear_sb();
      clear_obs();
      do_reset();

      // Reset state
      @(negedge clk);
      chk("rst_empty", int'(empty), 'hF);
      chk("rst_full", int'(full), 0);
      chk("rst_drop", int'(drop_err), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_data", int'(out_data), 0);
      chk("rst_ch", int'(out_ch), 0);

      // Accumulate-mode instance: first word fixed, rest random
      tick();
      for (int i = 0; i < 6; i++) begin
         ch = (i == 0) ? 2 : int'($urandom_range(0, NC - 1));
         w  = (i == 0) ? 8'h45 : W'($urandom);
         a_push[ch] = 1'b1;
         a_pdata[ch*W +: W] = w;
         tick();
         a_push = '0;
         k = 0;
         @(negedge clk);
         while (!a_valid && k < 20) begin
            @(negedge clk);
            k++;
         end
         chk("add_valid", int'(a_valid), 1);
         chk("add_data", int'(a_data), int'(ref_add(w)));
         chk("add_ch", int'(a_ch), ch);
         if (i == 0) chk("add_0x45", int'(a_data), 'h14);
         tick();
      end

      // Single word latency and value
      do_reset();
      out_ready = 1'b1;
      clear_obs();
      stage_push(0, 8'h81);
      tick();
      push = '0;
      c0 = cyc;
      drain(50, "lat");
      chk("lat_count", obs_cyc.size(), 1);
      if (obs_cyc.size() >= 1) begin
         chk("lat_cycles", obs_cyc[0] - c0, NL + 1);
         chk("lat_data", obs_dat[0], 'h0C);
         chk("lat_ch", obs_ch[0], 0);
      end

      // Same-cycle pushes on ch0, ch1, ch3: round-robin order and spacing
      do_reset();
      out_ready = 1'b1;
      clear_obs();
      stage_push(0, 8'h01);
      stage_push(1, 8'h01);
      stage_push(3, 8'h01);
      tick();
      push = '0;
      drain(100, "rr");
      chk("rr_count", obs_ch.size(), 3);
      if (obs_ch.size() == 3) begin
         chk("rr_first", obs_ch[0], 0);
         chk("rr_second", obs_ch[1], 1);
         chk("rr_third", obs_ch[2], 3);
         chk("rr_gap1", obs_cyc[1] - obs_cyc[0], NL + 2);
         chk("rr_gap2", obs_cyc[2] - obs_cyc[1], NL + 2);
      end

      // Overflow while engine is held in OUT, then stall stability
      do_reset();
      out_ready = 1'b0;
      clear_obs();
      stage_push(0, 8'hA5);
      tick();
      push = '0;
      k = 0;
      @(negedge clk);
      while (!out_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("hold_valid", int'(out_valid), 1);
      tick();
      for (int i = 0; i < 9; i++) begin
         if (i < 8) stage_push(1, W'(8'h10 + i));
         else begin
            push[1] = 1'b1;
            push_data[1*W +: W] = W'(8'h10 + i);
         end
         tick();
      end
      push = '0;
      @(negedge clk);
      chk("ovf_full1", int'(full[1]), 1);
      chk("ovf_drop1", int'(drop_err[1]), 1);
      chk("ovf_drop_others", int'(drop_err & 4'b1101), 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", int'(out_valid), 1);
         chk("stall_data", int'(out_data), 'h2D);
         chk("stall_ch", int'(out_ch), 0);
      end
      chk("stall_no_out", n_out - obs_ch.size() + obs_ch.size(), n_out);
      chk("stall_obs", obs_ch.size(), 0);
      tick();
      out_ready = 1'b1;
      drain(300, "ovf");
      chk("ovf_out_count", obs_ch.size(), 9);
      @(negedge clk);
      chk("ovf_drop_sticky", int'(drop_err[1]), 1);
      chk("ovf_full_after", int'(full[1]), 0);

      // Reset while the engine is looping with words still queued
      tick();
      out_ready = 1'b1;
      for (int c = 0; c < NC; c++) stage_push(c, W'($urandom));
      tick();
      push = '0;
      tick();
      rstn = 1'b1;
      clear_sb();
      tick();
      rstn = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_empty", int'(empty), 'hF);
      chk("mid_rst_drop", int'(drop_err), 0);
      chk("mid_rst_full", int'(full), 0);
      n0 = n_out;
      repeat (30) tick();
      chk("mid_rst_silent", n_out, n0);

      // Randomized traffic, throttled so no push can hit a full channel
      do_reset();
      n0 = n_out;
      for (int t = 0; t < 800; t++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         push = '0;
         for (int c = 0; c < NC; c++) begin
            if ($urandom_range(0, 5) == 0 && outst[c] < D) begin
               w = W'($urandom);
               stage_push(c, w);
            end
         end
         tick();
      end
      push = '0;
      out_ready = 1'b1;
      drain(2000, "rand");
      @(negedge clk);
      chk("rand_drop", int'(drop_err), 0);
      chk("rand_empty", int'(empty), 'hF);
      chk("rand_full", int'(full), 0);
      chk("rand_valid", int'(out_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mc_loop_fifo.md
MC_LOOP_FIFO -- requirements
Module: mc_loop_fifo

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of input channels, legal range 1-8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, entries per channel, power of 2, legal range 2-16.
REQ-003 SHALL have parameter FIFO_WIDTH, default 8, data width, legal range 8-16.
REQ-004 SHALL have parameter NUM_LOOPS, default 3, processing iterations, legal range 1-8.
REQ-005 SHALL have parameter ADD_MODE, default 0: 0 = rotate mode, 1 = accumulate mode.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-007 SHALL have port rstn, input, 1 bit: synchronous, active-high reset. The name is kept, but the polarity is high.
REQ-008 SHALL have port push, input, NUM_CH bits, per-channel write strobe.
REQ-009 SHALL have port push_data, input, NUM_CH*FIFO_WIDTH bits; channel c occupies bits [c*FIFO_WIDTH +: FIFO_WIDTH].
REQ-010 SHALL have port full, output, NUM_CH bits, per-channel full flag.
REQ-011 SHALL have port empty, output, NUM_CH bits, per-channel empty flag.
REQ-012 SHALL have port drop_err, output, NUM_CH bits, per-channel sticky overflow flag.
REQ-013 SHALL have port out_valid, output, 1 bit, result available.
REQ-014 SHALL have port out_ready, input, 1 bit, consumer accepts the result.
REQ-015 SHALL have port out_data, output, FIFO_WIDTH bits, processed word.
REQ-016 SHALL have port out_ch, output, clog2(NUM_CH) bits (minimum 1), source channel of out_data.

Function
REQ-017 Each channel SHALL be an independent FIFO_DEPTH-entry FIFO with wrapping read/write pointers and a count register of clog2(FIFO_DEPTH)+1 bits.
REQ-018 Flags SHALL be registered from the count: full = (count==FIFO_DEPTH), empty = (count==0).
REQ-019 A push SHALL be accepted when the channel is not full, or when the engine pops the same channel in the same cycle; both pointers advance and count is unchanged in that case.
REQ-020 A push that is not accepted SHALL be dropped with no state change except drop_err[c] <= 1; drop_err stays set until reset.
REQ-021 A push to an empty channel SHALL NOT bypass the FIFO; the word becomes poppable the next cycle.
REQ-022 The engine FSM SHALL have three states: IDLE, LOOP and OUT.
REQ-023 IDLE SHALL, if any channel is non-empty, pop the round-robin winner, load acc <= head word, load ch <= winner, clear iter, and go to LOOP. If all channels are empty, it stays in IDLE.
REQ-024 Round-robin SHALL search from last_served+1 with modulo-NUM_CH wrap and update last_served on each pop.
REQ-025 LOOP SHALL apply one operation per cycle for exactly NUM_LOOPS cycles, then go to OUT.
REQ-026 In ADD_MODE=0, each LOOP cycle SHALL perform acc <= rotate-left(acc,1).
REQ-027 In ADD_MODE=1, each LOOP cycle SHALL perform acc <= acc + loaded word, modulo 2^FIFO_WIDTH with the carry discarded, so the final result = word*(NUM_LOOPS+1) mod 2^FIFO_WIDTH.
REQ-028 OUT SHALL assert out_valid, with out_data = acc and out_ch = ch held stable until out_ready; on out_valid && out_ready the FSM goes to IDLE.
REQ-029 Latency SHALL be: pop in cycle T, out_valid first high in cycle T+NUM_LOOPS+1. Sustained throughput is one word per NUM_LOOPS+2 cycles with out_ready tied high.
REQ-030 out_valid SHALL NOT deassert without a handshake; out_ready while not in OUT SHALL be ignored.

Reset
REQ-031 rstn high at a clock edge SHALL clear all pointers, counts and drop_err, set empty = all ones and full = 0, force the FSM to IDLE, clear out_valid, out_data and out_ch, and set last_served = NUM_CH-1, regardless of state, including mid-LOOP or mid-OUT.
REQ-032 Pushes in a reset cycle SHALL be ignored; FIFO contents are discarded.

Verification
REQ-033 Defaults: after reset, push ch0 = 0x81 -> out_valid at push+1+NUM_LOOPS+1 cycles, out_data=0x0C, out_ch=0.
REQ-034 ADD_MODE=1, NUM_LOOPS=3: push ch2 = 0x45 -> out_data=0x14 (0x45*4 mod 256), out_ch=2.
REQ-035 Push 0x01 into ch0, ch1 and ch3 in the same cycle, with out_ready high -> outputs in order ch0, ch1, ch3, spaced NUM_LOOPS+2 cycles apart.
REQ-036 Push 9 words to ch1 (DEPTH=8) while out_ready is low and the engine is held in OUT on an earlier word -> 9th word dropped, drop_err[1]=1, full[1]=1; later drain yields the first 8 words in order.
REQ-037 Hold out_ready low for 5 cycles in OUT -> out_valid, out_data and out_ch stay stable; one handshake occurs when out_ready rises.
REQ-038 Assert rstn during LOOP with 3 words queued -> next cycle out_valid=0, empty=all ones, drop_err=0, and no output is produced afterwards.
